// File: rtl/cpu_alu.sv
// Beaker8 arithmetic/logic unit: combinational datapath with registered
// result byte and flag nibble ({V,N,Z,C}), one cycle of latency.
module cpu_alu #(
    parameter int         WIDTH      = 8,
    parameter logic [3:0] ALUOP_ADD  = 4'd0,
    parameter logic [3:0] ALUOP_ADC  = 4'd1,
    parameter logic [3:0] ALUOP_SUB  = 4'd2,
    parameter logic [3:0] ALUOP_SBC  = 4'd3,
    parameter logic [3:0] ALUOP_AND  = 4'd4,
    parameter logic [3:0] ALUOP_OR   = 4'd5,
    parameter logic [3:0] ALUOP_XOR  = 4'd6,
    parameter logic [3:0] ALUOP_NOT  = 4'd7,
    parameter logic [3:0] ALUOP_SHL  = 4'd8,
    parameter logic [3:0] ALUOP_SHR  = 4'd9,
    parameter logic [3:0] ALUOP_ROL  = 4'd10,
    parameter logic [3:0] ALUOP_ROR  = 4'd11,
    parameter logic [3:0] ALUOP_INC  = 4'd12,
    parameter logic [3:0] ALUOP_DEC  = 4'd13,
    parameter logic [3:0] ALUOP_CMP  = 4'd14,
    parameter logic [3:0] ALUOP_PASS = 4'd15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       operation,
    input  logic [3:0]       flagsIn,
    input  logic [WIDTH-1:0] leftOperand,
    input  logic [WIDTH-1:0] rightOperand,
    output logic [WIDTH-1:0] resultOut,
    output logic [3:0]       flagsOut
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             add_cin;
    logic             sub_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_v;
    logic             sub_v;

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_d;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] zn_src;
    logic             c_d;
    logic             v_d;

    // Z and N of the incoming flags are always recomputed, never copied.
    logic unused_flags;
    assign unused_flags = ^flagsIn[2:1];

    assign a   = leftOperand;
    assign b   = rightOperand;
    assign cin = flagsIn[0];

    // Shared adder and subtractor; carry-in only participates for ADC/SBC.
    always_comb begin
        add_cin = (operation == ALUOP_ADC) & cin;
        sub_cin = (operation == ALUOP_SBC) & cin;
        sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
        diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_cin};
        add_v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        sub_v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
    end

    always_comb begin
        result_d = a;
        c_d      = flagsIn[0];
        v_d      = flagsIn[3];
        zn_src   = '0;
        unique case (operation)
            ALUOP_ADD, ALUOP_ADC: begin
                result_d = sum[MSB:0];
                c_d      = sum[WIDTH];
                v_d      = add_v;
            end
            ALUOP_SUB, ALUOP_SBC: begin
                result_d = diff[MSB:0];
                c_d      = diff[WIDTH];
                v_d      = sub_v;
            end
            ALUOP_CMP: begin
                result_d = a;
                c_d      = diff[WIDTH];
                v_d      = sub_v;
            end
            ALUOP_AND:  result_d = a & b;
            ALUOP_OR:   result_d = a | b;
            ALUOP_XOR:  result_d = a ^ b;
            ALUOP_NOT:  result_d = ~a;
            ALUOP_SHL: begin
                result_d = {a[MSB-1:0], 1'b0};
                c_d      = a[MSB];
            end
            ALUOP_SHR: begin
                result_d = {1'b0, a[MSB:1]};
                c_d      = a[0];
            end
            ALUOP_ROL: begin
                result_d = {a[MSB-1:0], cin};
                c_d      = a[MSB];
            end
            ALUOP_ROR: begin
                result_d = {cin, a[MSB:1]};
                c_d      = a[0];
            end
            ALUOP_INC: begin
                result_d = a + {{(WIDTH-1){1'b0}}, 1'b1};
                v_d      = (a == {1'b0, {(WIDTH-1){1'b1}}});
            end
            ALUOP_DEC: begin
                result_d = a - {{(WIDTH-1){1'b0}}, 1'b1};
                v_d      = (a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            ALUOP_PASS: result_d = b;
        endcase
        // CMP reports Z/N of the difference while passing A through.
        zn_src  = (operation == ALUOP_CMP) ? diff[MSB:0] : result_d;
        flags_d = {v_d, zn_src[MSB], (zn_src == '0), c_d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign resultOut = result_q;
    assign flagsOut  = flags_q;

endmodule

// File: tb/tb_cpu_alu.sv
// Scoreboard bench for cpu_alu: driver pushes expected {flags,result},
// monitor pops one entry per clock and compares against the outputs.
module tb_cpu_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] operation;
    logic [3:0] flagsIn;
    logic [7:0] leftOperand;
    logic [7:0] rightOperand;
    logic [7:0] resultOut;
    logic [3:0] flagsOut;

    cpu_alu dut (
        .clk          (clk),
        .reset        (reset),
        .operation    (operation),
        .flagsIn      (flagsIn),
        .leftOperand  (leftOperand),
        .rightOperand (rightOperand),
        .resultOut    (resultOut),
        .flagsOut     (flagsOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: integer arithmetic from the signed/unsigned rules.
    function automatic logic [11:0] model(input logic [3:0] op,
                                          input logic [3:0] fi,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        int ua, ub, ci, sa, sb, t, st, r, zv;
        bit c, v;
        ua = int'(a);
        ub = int'(b);
        ci = int'(fi[0]);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        c  = fi[0];
        v  = fi[3];
        r  = ua;
        zv = -1;
        case (op)
            4'd0, 4'd1: begin
                t = ua + ub + ((op == 4'd1) ? ci : 0);
                st = sa + sb + ((op == 4'd1) ? ci : 0);
                r = t & 255; c = (t > 255); v = (st > 127) || (st < -128);
            end
            4'd2, 4'd3, 4'd14: begin
                t = ua - ub - ((op == 4'd3) ? ci : 0);
                st = sa - sb - ((op == 4'd3) ? ci : 0);
                r = t & 255; c = (t < 0); v = (st > 127) || (st < -128);
                if (op == 4'd14) begin zv = r; r = ua; end
            end
            4'd4:  r = ua & ub;
            4'd5:  r = ua | ub;
            4'd6:  r = ua ^ ub;
            4'd7:  r = 255 - ua;
            4'd8:  begin r = (ua * 2) & 255; c = (ua >= 128); end
            4'd9:  begin r = ua / 2; c = (ua % 2) == 1; end
            4'd10: begin r = (ua * 2 + ci) & 255; c = (ua >= 128); end
            4'd11: begin r = ua / 2 + ci * 128; c = (ua % 2) == 1; end
            4'd12: begin r = (ua + 1) & 255; v = (ua == 127); end
            4'd13: begin r = (ua + 255) & 255; v = (ua == 128); end
            default: r = ub;
        endcase
        if (zv < 0) zv = r;
        model = {v, (zv >= 128), (zv == 0), c, 8'(r)};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [3:0] fi,
                         input logic [7:0] a, input logic [7:0] b);
        @(posedge clk);
        #2;
        operation = op; flagsIn = fi; leftOperand = a; rightOperand = b;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] fi,
                         input logic [7:0] a, input logic [7:0] b);
        logic [11:0] m;
        exp_t e;
        drive(op, fi, a, b);
        m = model(op, fi, a, b);
        e.r = m[7:0]; e.f = m[11:8];
        e.tag = $sformatf("op%0d a=%02h b=%02h f=%04b", op, a, b, fi);
        sb_q.push_back(e);
    endtask

    task automatic issue_exp(input string tag, input logic [3:0] op,
                             input logic [3:0] fi, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] er,
                             input logic [3:0] ef);
        exp_t e;
        drive(op, fi, a, b);
        e.r = er; e.f = ef; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if (resultOut !== 8'h00 || flagsOut !== 4'b0000) begin
            n_err++;
            $display("FAIL %s: got %02h/%04b want 00/0000",
                     tag, resultOut, flagsOut);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare whenever one is owed.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                n_vec++;
                if (resultOut !== e.r || flagsOut !== e.f) begin
                    n_err++;
                    $display("FAIL %s: got %02h/%04b want %02h/%04b",
                             e.tag, resultOut, flagsOut, e.r, e.f);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1'b0;
        operation = 4'd0; flagsIn = 4'b0000;
        leftOperand = 8'h12; rightOperand = 8'h34;
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        reset = 1'b1;
        e.r = 8'h46; e.f = 4'b0000; e.tag = "reset_release_add";
        sb_q.push_back(e);

        issue_exp("add_ovf",   4'd0,  4'b0000, 8'h7F, 8'h01, 8'h80, 4'b1100);
        issue_exp("add_carry", 4'd0,  4'b0000, 8'hFF, 8'h01, 8'h00, 4'b0011);
        issue_exp("sub_borrow",4'd2,  4'b0000, 8'h00, 8'h01, 8'hFF, 4'b0101);
        issue_exp("cmp_eq",    4'd14, 4'b0000, 8'h05, 8'h05, 8'h05, 4'b0010);
        issue_exp("sbc_cin",   4'd3,  4'b0001, 8'h10, 8'h0F, 8'h00, 4'b0010);
        issue_exp("adc_cin",   4'd1,  4'b0001, 8'hFF, 8'h00, 8'h00, 4'b0011);
        issue_exp("ror_cin",   4'd11, 4'b0001, 8'h01, 8'h00, 8'h80, 4'b0101);
        issue_exp("shl",       4'd8,  4'b0000, 8'h81, 8'h00, 8'h02, 4'b0001);
        issue_exp("and_keep",  4'd4,  4'b1001, 8'hF0, 8'h0F, 8'h00, 4'b1011);
        issue_exp("inc_wrap",  4'd12, 4'b0001, 8'hFF, 8'h00, 8'h00, 4'b0011);
        issue_exp("dec_ovf",   4'd13, 4'b0000, 8'h80, 8'h00, 8'h7F, 4'b1000);
        issue_exp("cmp_lt",    4'd14, 4'b0000, 8'h03, 8'h07, 8'h03, 4'b0101);

        for (int op = 0; op < 16; op++)
            issue(4'(op), 4'($urandom), 8'($urandom), 8'($urandom));

        // Mid-stream reset: in-flight op is dropped, outputs clear at once.
        issue_exp("pre_reset", 4'd0, 4'b0000, 8'h01, 8'h01, 8'h02, 4'b0000);
        issue(4'd15, 4'b0000, 8'h00, 8'h5A);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_edge_hold");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 300; i++)
            issue(4'($urandom_range(0, 15)), 4'($urandom),
                  8'($urandom), 8'($urandom));

        repeat (3) @(posedge clk);
        #3;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_alu.md
# cpu_alu

Combinational-datapath, registered-output 8-bit arithmetic/logic unit for the Beaker8 CPU core. It is instantiated inside `Cpu`, which drives the operation code, the current flag register and two operands. It takes back the result byte and the updated flag nibble one clock later. The block holds no architectural state other than its output registers.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width; all rules below are written for 8.
- `ALUOP_*`, 4-bit constants: ADD=0, ADC=1, SUB=2, SBC=3, AND=4, OR=5, XOR=6, NOT=7, SHL=8, SHR=9, ROL=10, ROR=11, INC=12, DEC=13, CMP=14, PASS=15.

Ports:
- `clk` input 1: single clock; everything is sampled on its rising edge.
- `reset` input 1: asynchronous, active-low reset. Clearing is immediate on assertion; release is synchronous to `clk` by the parent.
- `operation` input 4: ALUOP code.
- `flagsIn` input 4: current CPU flags.
- `leftOperand` input 8: operand A.
- `rightOperand` input 8: operand B.
- `resultOut` output 8: registered result.
- `flagsOut` output 4: registered flags.

Flag bit order, for both flag ports: [0]=C (carry/borrow), [1]=Z (zero), [2]=N (negative), [3]=V (signed overflow).

## Operation
- Every cycle, compute result R and flags F from the current inputs, then register them into `resultOut`/`flagsOut`. There is no enable; the registers load every cycle.
- Z is always (R==0) and N is always R[7], except for CMP, where Z and N come from the difference.
- ADD: R=A+B. C=carry out of bit 7. V=(A[7]==B[7])&&(R[7]!=A[7]).
- ADC: R=A+B+Cin, where Cin=flagsIn[0]. C and V as for ADD, over the 9-bit sum.
- SUB: R=A-B. C=borrow (1 when A<B unsigned). V=(A[7]!=B[7])&&(R[7]!=A[7]).
- SBC: R=A-B-Cin. C=borrow out of the 9-bit difference. V as for SUB.
- CMP: compute D=A-B and set C, Z, N, V from D as for SUB. The result is R=A, so the operand passes through unchanged.
- AND, OR, XOR: bitwise A op B. NOT: R=~A. For all four, C and V are copied from flagsIn.
- SHL: R={A[6:0],0}, C=A[7]. SHR: R={0,A[7:1]}, C=A[0]. For both, V is copied.
- ROL: R={A[6:0],Cin}, C=A[7]. ROR: R={Cin,A[7:1]}, C=A[0]. Both rotate through carry; V is copied.
- INC: R=A+1. DEC: R=A-1. For both, C is copied. V=1 only for INC 0x7F→0x80 and DEC 0x80→0x7F.
- PASS: R=B. C and V are copied.
- `rightOperand` is ignored by NOT, the shifts, the rotates, INC and DEC.
- All arithmetic wraps modulo 256.

## Timing
- Latency is exactly 1 cycle: inputs present before rising edge k appear on the outputs after edge k.
- Back-to-back operations are supported at full rate, one per cycle, with no stalls.
- Reset: while `reset`=0, `resultOut`=0x00 and `flagsOut`=4'b0000 regardless of `clk` or the inputs.
- On reset release, the first rising edge with `reset`=1 loads the computed values.
- Reset asserted mid-stream discards the in-flight result; no partial update is visible afterwards.
- Unknown or X `operation` does not occur; all 16 codes are defined, so there is no default hazard.
- No combinational path from inputs to outputs.

## Test plan
- Reset: drive `reset`=0 with ADD 0x12+0x34 and toggle `clk` → outputs stay 0x00/0000. Release reset, one edge → 0x46, flags 0000.
- ADD overflow: 0x7F+0x01, flagsIn 0000 → R=0x80, flagsOut=1100 (V,N). Then ADD 0xFF+0x01 → R=0x00, flagsOut=0011 (Z,C).
- SUB/CMP borrow: SUB 0x00-0x01 → 0xFF, flags 0101 (N,C). CMP 0x05,0x05 → R=0x05, flags 0010 (Z). SBC 0x10-0x0F with Cin=1 → 0x00, flags 0010.
- Carry-in ops: ADC 0xFF+0x00 with Cin=1 → 0x00, flags 0011. ROR 0x01 with Cin=1 → 0x80, flags 0101. SHL 0x81 → 0x02, flags 0001.
- Flag preservation: flagsIn=1001, AND 0xF0&0x0F → 0x00, flags 1011. INC 0xFF with flagsIn=0001 → 0x00, flags 0011. DEC 0x80 → 0x7F, V=1.
- Pipelining and reset mid-stream: a new op every cycle for 16 cycles covering all codes → each result appears exactly one edge later. Assert `reset` between edges → outputs go to 0 immediately.
